// File: rtl/mdu_unit_if.sv
// Bus bundle between the controller/datapath and the multiply/divide unit.
// The master drives the operation request; the slave returns Busy and HI/LO.
interface mdu_unit_if;
   logic        Start;
   logic [2:0]  MDUOp;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MDUOp, SrcA, SrcB,
      input  Busy, HI, LO
   );

   modport slave (
      input  Start, MDUOp, SrcA, SrcB,
      output Busy, HI, LO
   );
endinterface

// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the HI/LO registers.
// mult/multu/div/divu compute their full result when they are accepted, then
// hold Busy for a fixed number of cycles before committing it to HI/LO.
// mthi/mtlo write a single register immediately.
module mdu_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic        clk,
   input logic        reset,
   mdu_unit_if.slave  bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic [0:0]  state_q,   state_d;
   logic [4:0]  count_q,   count_d;
   logic [31:0] hi_q,      hi_d;
   logic [31:0] lo_q,      lo_d;
   logic [31:0] resHi_q,   resHi_d;
   logic [31:0] resLo_q,   resLo_d;
   logic        resKeep_q, resKeep_d;

   logic [63:0] prodS;
   logic [63:0] prodU;
   logic        negA;
   logic        negB;
   logic [31:0] magA;
   logic [31:0] magB;
   logic [31:0] safeB;
   logic [31:0] safeMagB;
   logic [31:0] quoU;
   logic [31:0] remU;
   logic [31:0] quoMag;
   logic [31:0] remMag;
   logic [31:0] quoS;
   logic [31:0] remS;

   // Operand arithmetic for every operation, evaluated on the live bus operands.
   // Signed division works on magnitudes so that 0x80000000 / -1 simply wraps
   // back to 0x80000000 instead of overflowing; a zero divisor is replaced by
   // one purely to keep the divider defined, and the result is then discarded.
   always_comb begin
      prodS    = $signed({{32{bus.SrcA[31]}}, bus.SrcA}) * $signed({{32{bus.SrcB[31]}}, bus.SrcB});
      prodU    = {32'd0, bus.SrcA} * {32'd0, bus.SrcB};
      negA     = bus.SrcA[31];
      negB     = bus.SrcB[31];
      magA     = negA ? (32'd0 - bus.SrcA) : bus.SrcA;
      magB     = negB ? (32'd0 - bus.SrcB) : bus.SrcB;
      safeB    = (bus.SrcB == 32'd0) ? 32'd1 : bus.SrcB;
      safeMagB = (magB == 32'd0) ? 32'd1 : magB;
      quoU     = bus.SrcA / safeB;
      remU     = bus.SrcA % safeB;
      quoMag   = magA / safeMagB;
      remMag   = magA % safeMagB;
      quoS     = (negA ^ negB) ? (32'd0 - quoMag) : quoMag;
      remS     = negA ? (32'd0 - remMag) : remMag;
   end

   // Next-state logic: accept a request while idle, count down while running,
   // and commit the held result on the final countdown edge.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      resHi_d   = resHi_q;
      resLo_d   = resLo_q;
      resKeep_d = resKeep_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               case (bus.MDUOp)
                  OP_MULT: begin
                     resHi_d   = prodS[63:32];
                     resLo_d   = prodS[31:0];
                     resKeep_d = 1'b1;
                     count_d   = 5'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MULTU: begin
                     resHi_d   = prodU[63:32];
                     resLo_d   = prodU[31:0];
                     resKeep_d = 1'b1;
                     count_d   = 5'(MULT_CYCLES);
                     state_d   = RUN;
                  end
                  OP_DIV: begin
                     resHi_d   = remS;
                     resLo_d   = quoS;
                     resKeep_d = (bus.SrcB != 32'd0);
                     count_d   = 5'(DIV_CYCLES);
                     state_d   = RUN;
                  end
                  OP_DIVU: begin
                     resHi_d   = remU;
                     resLo_d   = quoU;
                     resKeep_d = (bus.SrcB != 32'd0);
                     count_d   = 5'(DIV_CYCLES);
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = bus.SrcA;
                  OP_MTLO: lo_d = bus.SrcA;
                  default: ;
               endcase
            end
         end
         default: begin
            count_d = count_q - 5'd1;
            if (count_q == 5'd1) begin
               state_d = IDLE;
               if (resKeep_q) begin
                  hi_d = resHi_q;
                  lo_d = resLo_q;
               end
            end
         end
      endcase
   end

   // State registers; reset abandons any operation in flight and clears HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= 5'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         resHi_q   <= 32'd0;
         resLo_q   <= 32'd0;
         resKeep_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         resHi_q   <= resHi_d;
         resLo_q   <= resLo_d;
         resKeep_q <= resKeep_d;
      end
   end

   assign bus.Busy = (state_q == RUN);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multiply/divide unit for the next datapath revision, adding mult/multu/div/divu/mthi/mtlo. It sits directly downstream of the register file and consumes the rs/rt read data (RD1/RD2) alongside the ALU. It holds the HI/LO registers that mfhi/mflo read back through the register-write mux. Multi-cycle operations raise Busy so the controller can stall dependent MDU instructions.

Parameters:
MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (legal range 1..31)
DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (legal range 1..31)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
Start  input  1  qualifies MDUOp for one cycle
MDUOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
SrcA  input  32  operand A (GRF rs data)
SrcB  input  32  operand B (GRF rt data)
Busy  output  1  high while a mult/div is in flight
HI  output  32  HI register
LO  output  32  LO register

Behaviour:
- Reset (async, active-high): HI=0, LO=0, Busy=0, cycle counter=0, internal result latches=0. Any in-flight operation is discarded. Nothing is written to HI/LO.
- FSM has two states, IDLE and RUN. Reset forces IDLE.
- Acceptance:
  - In IDLE, a rising edge with Start=1 and MDUOp in 1..4 samples SrcA/SrcB and MDUOp.
  - The full result is computed from the sampled operands and held internally.
  - The counter loads MULT_CYCLES or DIV_CYCLES and the FSM enters RUN.
- Busy = (state==RUN). It is registered, so it rises the cycle after the Start cycle.
- RUN:
  - The counter decrements each edge.
  - On the edge where the counter goes 1->0, HI/LO are written from the internal result and the FSM returns to IDLE.
- Latency: Start sampled at edge E0, Busy high from E0 through edge E0+N, where N is the cycle count.
  - New HI/LO and Busy=0 are visible together after edge E0+N.
  - While Busy=1, HI/LO keep their old values.
- mthi/mtlo: in IDLE with Start=1, HI<=SrcA (mthi) or LO<=SrcA (mtlo) at that edge. Zero latency, no Busy, the other register is unchanged.
- Start while Busy=1: ignored for every MDUOp. There is no queueing and the in-flight op is unaffected. The controller must stall instead.
- Start with MDUOp 0 or 7: no effect.
- Operand changes after acceptance have no effect.
- Arithmetic:
  - mult: {HI,LO} = signed(SrcA) * signed(SrcB), 64-bit.
  - multu: same as mult, unsigned.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend (SrcA).
  - divu: unsigned quotient/remainder.
- Division boundary cases:
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (no trap).
  - Divisor 0 (div or divu): Busy still runs DIV_CYCLES cycles, then HI and LO are left unchanged.
- Back-to-back: a new Start is accepted on the first edge where the FSM is IDLE.
  - For example, Start held high with Busy falling after E0+N gives a new acceptance at E0+N+1.
  - Busy is therefore low for exactly one cycle between the two operations.
- Reset asserted mid-RUN: Busy drops immediately (asynchronously), HI/LO go to 0, and the pending result is lost.

Test Plan:
- Reset, then Start mult with SrcA=0xFFFFFFFE (-2), SrcB=0x00000003 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- multu with SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO hold their old values during Busy.
- div with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with 7/2 -> LO=3, HI=1. Then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi with SrcA=0x12345678 -> HI=0x12345678 on the next edge, Busy stays 0. Next, start div by 0 -> Busy for 10 cycles, then HI=0x12345678 and LO unchanged.
- Start div, then pulse Start with mtlo SrcA=0xDEADBEEF at cycle 3 of Busy -> mtlo ignored, div result written after 10 cycles. Then mtlo issued when Busy=0 -> LO=0xDEADBEEF.
- Start mult, assert reset at cycle 2 of Busy -> Busy, HI, LO are 0 immediately. After release, no late write occurs and a fresh mult completes in 5 cycles.
